// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue front end: internal opcode numbering,
// RV32I major opcodes and the packed operation record held in the output stage.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [7:0] ALU_OPC_ADDI  = 8'd14;
  localparam logic [7:0] ALU_OPC_SLTI  = 8'd15;
  localparam logic [7:0] ALU_OPC_SLTIU = 8'd16;
  localparam logic [7:0] ALU_OPC_XORI  = 8'd17;
  localparam logic [7:0] ALU_OPC_ORI   = 8'd18;
  localparam logic [7:0] ALU_OPC_ANDI  = 8'd19;
  localparam logic [7:0] ALU_OPC_SLLI  = 8'd20;
  localparam logic [7:0] ALU_OPC_SRLI  = 8'd21;
  localparam logic [7:0] ALU_OPC_SRAI  = 8'd22;
  localparam logic [7:0] ALU_OPC_ADD   = 8'd23;
  localparam logic [7:0] ALU_OPC_SUB   = 8'd24;
  localparam logic [7:0] ALU_OPC_SLL   = 8'd25;
  localparam logic [7:0] ALU_OPC_SLT   = 8'd26;
  localparam logic [7:0] ALU_OPC_SLTU  = 8'd27;
  localparam logic [7:0] ALU_OPC_XOR   = 8'd28;
  localparam logic [7:0] ALU_OPC_SRL   = 8'd29;
  localparam logic [7:0] ALU_OPC_SRA   = 8'd30;
  localparam logic [7:0] ALU_OPC_OR    = 8'd31;
  localparam logic [7:0] ALU_OPC_AND   = 8'd32;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
  } issue_pkt_t;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction-in and operation-out handshakes of the ALU issue stage.
// master = instruction source / ALU sink side, slave = the issue stage itself.
interface alu_issue_if #(
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_opcode;
  logic [31:0]      out_rs1;
  logic [31:0]      out_rs2;
  logic [31:0]      out_imm;
  logic [4:0]       out_rd;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_imm, out_rd, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_imm, out_rd, out_tag
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP-IMM/OP decoder: maps an instruction word onto the
// internal ALU opcode, immediate and register indices, and flags legality.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [7:0]  opcode,
  output logic [31:0] imm,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic [4:0]  rd_idx,
  output logic        is_rtype,
  output logic        legal
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;

  assign op      = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign rd_idx  = instr[11:7];

  always_comb begin
    opcode   = '0;
    imm      = '0;
    is_rtype = 1'b0;
    legal    = 1'b0;
    unique case (op)
      OPC_OP_IMM: begin
        imm   = {{20{instr[31]}}, instr[31:20]};
        legal = 1'b1;
        unique case (f3)
          3'b000: opcode = ALU_OPC_ADDI;
          3'b010: opcode = ALU_OPC_SLTI;
          3'b011: opcode = ALU_OPC_SLTIU;
          3'b100: opcode = ALU_OPC_XORI;
          3'b110: opcode = ALU_OPC_ORI;
          3'b111: opcode = ALU_OPC_ANDI;
          // Shift immediates reuse the upper immediate bits as a funct7 field
          3'b001: begin
            imm    = {27'b0, instr[24:20]};
            opcode = ALU_OPC_SLLI;
            legal  = (f7 == F7_ZERO);
          end
          3'b101: begin
            imm = {27'b0, instr[24:20]};
            if (f7 == F7_ZERO)     opcode = ALU_OPC_SRLI;
            else if (f7 == F7_ALT) opcode = ALU_OPC_SRAI;
            else                   legal  = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        is_rtype = 1'b1;
        legal    = 1'b1;
        unique case ({f7, f3})
          {F7_ZERO, 3'b000}: opcode = ALU_OPC_ADD;
          {F7_ALT,  3'b000}: opcode = ALU_OPC_SUB;
          {F7_ZERO, 3'b001}: opcode = ALU_OPC_SLL;
          {F7_ZERO, 3'b010}: opcode = ALU_OPC_SLT;
          {F7_ZERO, 3'b011}: opcode = ALU_OPC_SLTU;
          {F7_ZERO, 3'b100}: opcode = ALU_OPC_XOR;
          {F7_ZERO, 3'b101}: opcode = ALU_OPC_SRL;
          {F7_ALT,  3'b101}: opcode = ALU_OPC_SRA;
          {F7_ZERO, 3'b110}: opcode = ALU_OPC_OR;
          {F7_ZERO, 3'b111}: opcode = ALU_OPC_AND;
          default:           legal  = 1'b0;
        endcase
      end
      default: ;
    endcase
    if (!legal) begin
      opcode = '0;
      imm    = '0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue front end: decodes incoming words, stalls on scoreboard hazards and
// hands operations to the ALU through a single-entry output register.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_if.slave       bus,
  output logic [4:0]       rf_rs1_addr,
  output logic [4:0]       rf_rs2_addr,
  input  logic [31:0]      rf_rs1_data,
  input  logic [31:0]      rf_rs2_data,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             illegal
);

  logic [7:0]  dec_opcode;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_rtype;
  logic        dec_legal;

  alu_issue_decode u_decode (
    .instr    (bus.in_instr),
    .opcode   (dec_opcode),
    .imm      (dec_imm),
    .rs1_idx  (dec_rs1),
    .rs2_idx  (dec_rs2),
    .rd_idx   (dec_rd),
    .is_rtype (dec_rtype),
    .legal    (dec_legal)
  );

  assign rf_rs1_addr = dec_rs1;
  assign rf_rs2_addr = dec_rs2;

  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  issue_pkt_t       pkt_q;
  issue_pkt_t       pkt_d;
  logic [TAG_W-1:0] tag_q;
  logic             out_valid_q;
  logic             illegal_q;

  logic hazard;
  logic can_load;
  logic in_ready;
  logic accept;
  logic issue;

  // Illegal words never wait: they are dropped without touching the pipeline
  assign hazard   = busy_q[dec_rs1] | (dec_rtype & busy_q[dec_rs2]) | busy_q[dec_rd];
  assign can_load = ~out_valid_q | bus.out_ready;
  assign in_ready = dec_legal ? (can_load & ~hazard) : 1'b1;
  assign accept   = bus.in_valid & in_ready;
  assign issue    = accept & dec_legal;

  always_comb begin
    pkt_d.opcode = dec_opcode;
    pkt_d.rs1    = rf_rs1_data;
    pkt_d.rs2    = rf_rs2_data;
    pkt_d.imm    = dec_imm;
    pkt_d.rd     = dec_rd;
  end

  // Writeback clear is applied first so a same-edge issue to that rd keeps it busy
  always_comb begin
    busy_d = busy_q;
    if (wb_valid)
      busy_d[wb_rd] = 1'b0;
    if (issue)
      busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q       <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= '0;
    end else begin
      busy_q    <= busy_d;
      illegal_q <= accept & ~dec_legal;
      if (issue) begin
        pkt_q       <= pkt_d;
        tag_q       <= bus.in_tag;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_opcode = pkt_q.opcode;
  assign bus.out_rs1    = pkt_q.rs1;
  assign bus.out_rs2    = pkt_q.rs2;
  assign bus.out_imm    = pkt_q.imm;
  assign bus.out_rd     = pkt_q.rd;
  assign bus.out_tag    = tag_q;
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a decode vector table plus hand sequences for
// back-to-back issue, RAW stall, backpressure, illegal words and async reset.
module tb_alu_issue;

  localparam int TAG_W = 4;
  localparam int NV    = 25;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  opc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ill;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        illegal;

  int total;
  int passed;

  vec_t vecs [NV];

  alu_issue_if #(.TAG_W(TAG_W)) bus ();

  alu_issue #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .illegal     (illegal)
  );

  // Register file model: x[i] holds i*16, so x0 reads as zero
  assign rf_rs1_data = {23'b0, rf_rs1_addr, 4'b0};
  assign rf_rs2_data = {23'b0, rf_rs2_addr, 4'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      passed++;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [TAG_W-1:0] tag, input logic oready);
    @(negedge clk);
    bus.in_valid  = valid;
    bus.in_instr  = instr;
    bus.in_tag    = tag;
    bus.out_ready = oready;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic clearBusy(input logic [4:0] rd);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wb_valid      = 1'b1;
    wb_rd         = rd;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  initial begin
    total         = 0;
    passed        = 0;
    rst           = 1'b1;
    wb_valid      = 1'b0;
    wb_rd         = '0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    vecs[0]  = '{32'hFFD08293,               8'd14, 32'hFFFFFFFD, 5'd5,  32'h10,  32'h1D0, 1'b0};
    vecs[1]  = '{enc_i(12'd100, 2, 3'd2, 9),   8'd15, 32'h00000064, 5'd9,  32'h20,  32'h040, 1'b0};
    vecs[2]  = '{enc_i(12'hFFF, 3, 3'd3, 10),  8'd16, 32'hFFFFFFFF, 5'd10, 32'h30,  32'h1F0, 1'b0};
    vecs[3]  = '{enc_i(12'h7FF, 4, 3'd4, 11),  8'd17, 32'h000007FF, 5'd11, 32'h40,  32'h1F0, 1'b0};
    vecs[4]  = '{enc_i(12'h800, 5, 3'd6, 12),  8'd18, 32'hFFFFF800, 5'd12, 32'h50,  32'h000, 1'b0};
    vecs[5]  = '{enc_i(12'h0F0, 6, 3'd7, 13),  8'd19, 32'h000000F0, 5'd13, 32'h60,  32'h100, 1'b0};
    vecs[6]  = '{enc_i(12'h01F, 7, 3'd1, 14),  8'd20, 32'h0000001F, 5'd14, 32'h70,  32'h1F0, 1'b0};
    vecs[7]  = '{enc_i(12'h003, 8, 3'd5, 15),  8'd21, 32'h00000003, 5'd15, 32'h80,  32'h030, 1'b0};
    vecs[8]  = '{32'h40435393,               8'd22, 32'h00000004, 5'd7,  32'h60,  32'h040, 1'b0};
    vecs[9]  = '{enc_r(7'h00, 2, 1, 3'd0, 16),  8'd23, 32'h0, 5'd16, 32'h10,  32'h20,  1'b0};
    vecs[10] = '{32'h402081B3,                8'd24, 32'h0, 5'd3,  32'h10,  32'h20,  1'b0};
    vecs[11] = '{enc_r(7'h00, 3, 4, 3'd1, 17),  8'd25, 32'h0, 5'd17, 32'h40,  32'h30,  1'b0};
    vecs[12] = '{enc_r(7'h00, 5, 6, 3'd2, 18),  8'd26, 32'h0, 5'd18, 32'h60,  32'h50,  1'b0};
    vecs[13] = '{enc_r(7'h00, 7, 8, 3'd3, 19),  8'd27, 32'h0, 5'd19, 32'h80,  32'h70,  1'b0};
    vecs[14] = '{enc_r(7'h00, 9, 10, 3'd4, 20), 8'd28, 32'h0, 5'd20, 32'hA0,  32'h90,  1'b0};
    vecs[15] = '{enc_r(7'h00, 11, 12, 3'd5, 21), 8'd29, 32'h0, 5'd21, 32'hC0, 32'hB0,  1'b0};
    vecs[16] = '{enc_r(7'h20, 13, 14, 3'd5, 22), 8'd30, 32'h0, 5'd22, 32'hE0, 32'hD0,  1'b0};
    vecs[17] = '{enc_r(7'h00, 15, 16, 3'd6, 23), 8'd31, 32'h0, 5'd23, 32'h100, 32'hF0, 1'b0};
    vecs[18] = '{enc_r(7'h00, 17, 18, 3'd7, 24), 8'd32, 32'h0, 5'd24, 32'h120, 32'h110, 1'b0};
    vecs[19] = '{enc_i(12'h001, 1, 3'd0, 0),   8'd14, 32'h00000001, 5'd0, 32'h10, 32'h010, 1'b0};
    vecs[20] = '{32'h0000007F,               8'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b1};
    vecs[21] = '{32'h02109093,               8'd0, 32'h0, 5'd1, 32'h0, 32'h0, 1'b1};
    vecs[22] = '{enc_r(7'h20, 1, 2, 3'd1, 5),  8'd0, 32'h0, 5'd5, 32'h0, 32'h0, 1'b1};
    vecs[23] = '{enc_r(7'h01, 1, 2, 3'd0, 5),  8'd0, 32'h0, 5'd5, 32'h0, 32'h0, 1'b1};
    vecs[24] = '{enc_i(12'h023, 1, 3'd5, 4),   8'd0, 32'h0, 5'd4, 32'h0, 32'h0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid",  32'(bus.out_valid), 32'd0);
    checkOutput("reset out_opcode", 32'(bus.out_opcode), 32'd0);
    checkOutput("reset out_rs1",    bus.out_rs1, 32'd0);
    checkOutput("reset out_rs2",    bus.out_rs2, 32'd0);
    checkOutput("reset out_imm",    bus.out_imm, 32'd0);
    checkOutput("reset out_rd",     32'(bus.out_rd), 32'd0);
    checkOutput("reset out_tag",    32'(bus.out_tag), 32'd0);
    checkOutput("reset illegal",    32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Decode table: one op at a time, each retired by a writeback
    for (int i = 0; i < NV; i++) begin
      applyStimulus(1'b1, vecs[i].instr, i[TAG_W-1:0], 1'b1);
      checkOutput($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      checkOutput($sformatf("v%0d rf_rs1_addr", i), 32'(rf_rs1_addr), 32'(vecs[i].instr[19:15]));
      stepEdge();
      checkOutput($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(!vecs[i].ill));
      checkOutput($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
      if (!vecs[i].ill) begin
        checkOutput($sformatf("v%0d opcode", i), 32'(bus.out_opcode), 32'(vecs[i].opc));
        checkOutput($sformatf("v%0d imm", i), bus.out_imm, vecs[i].imm);
        checkOutput($sformatf("v%0d rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
        checkOutput($sformatf("v%0d rs1", i), bus.out_rs1, vecs[i].rs1);
        checkOutput($sformatf("v%0d rs2", i), bus.out_rs2, vecs[i].rs2);
        checkOutput($sformatf("v%0d tag", i), 32'(bus.out_tag), 32'(i % 16));
      end
      clearBusy(vecs[i].rd);
      if (vecs[i].ill)
        checkOutput($sformatf("v%0d illegal pulse end", i), 32'(illegal), 32'd0);
    end

    // SUB then SRAI back-to-back
    applyStimulus(1'b1, 32'h402081B3, 4'd1, 1'b1);
    checkOutput("b2b sub in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("b2b sub opcode", 32'(bus.out_opcode), 32'd24);
    applyStimulus(1'b1, 32'h40435393, 4'd2, 1'b1);
    checkOutput("b2b srai in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("b2b srai valid", 32'(bus.out_valid), 32'd1);
    checkOutput("b2b srai opcode", 32'(bus.out_opcode), 32'd22);
    checkOutput("b2b srai imm", bus.out_imm, 32'd4);
    clearBusy(5'd3);
    clearBusy(5'd7);

    // RAW hazard on x5, released only the cycle after writeback
    applyStimulus(1'b1, 32'hFFD08293, 4'd3, 1'b1);
    stepEdge();
    checkOutput("raw addi opcode", 32'(bus.out_opcode), 32'd14);
    applyStimulus(1'b1, enc_r(7'h00, 0, 5, 3'd0, 6), 4'd4, 1'b1);
    checkOutput("raw stall1 in_ready", 32'(bus.in_ready), 32'd0);
    stepEdge();
    checkOutput("raw stall1 out_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, enc_r(7'h00, 0, 5, 3'd0, 6), 4'd4, 1'b1);
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    #1;
    checkOutput("raw wb-cycle in_ready", 32'(bus.in_ready), 32'd0);
    stepEdge();
    wb_valid = 1'b0;
    checkOutput("raw wb-cycle out_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, enc_r(7'h00, 0, 5, 3'd0, 6), 4'd4, 1'b1);
    checkOutput("raw release in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("raw add valid", 32'(bus.out_valid), 32'd1);
    checkOutput("raw add opcode", 32'(bus.out_opcode), 32'd23);
    checkOutput("raw add rs1", bus.out_rs1, 32'h50);
    checkOutput("raw add rd", 32'(bus.out_rd), 32'd6);
    clearBusy(5'd6);

    // Backpressure: hold for 3 cycles, then 1 op/cycle
    applyStimulus(1'b1, enc_r(7'h00, 2, 1, 3'd0, 16), 4'd5, 1'b0);
    stepEdge();
    checkOutput("bp add opcode", 32'(bus.out_opcode), 32'd23);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, enc_r(7'h00, 5, 6, 3'd2, 18), 4'd6, 1'b0);
      checkOutput($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      stepEdge();
      checkOutput($sformatf("bp hold%0d valid", k), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("bp hold%0d opcode", k), 32'(bus.out_opcode), 32'd23);
      checkOutput($sformatf("bp hold%0d rs1", k), bus.out_rs1, 32'h10);
      checkOutput($sformatf("bp hold%0d rs2", k), bus.out_rs2, 32'h20);
      checkOutput($sformatf("bp hold%0d rd", k), 32'(bus.out_rd), 32'd16);
      checkOutput($sformatf("bp hold%0d tag", k), 32'(bus.out_tag), 32'd5);
    end
    applyStimulus(1'b1, enc_r(7'h00, 5, 6, 3'd2, 18), 4'd6, 1'b1);
    checkOutput("bp release in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("bp slt opcode", 32'(bus.out_opcode), 32'd26);
    checkOutput("bp slt rd", 32'(bus.out_rd), 32'd18);
    applyStimulus(1'b1, enc_r(7'h00, 9, 10, 3'd4, 20), 4'd7, 1'b1);
    checkOutput("bp xor in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("bp xor opcode", 32'(bus.out_opcode), 32'd28);
    applyStimulus(1'b0, 32'h0, 4'd0, 1'b1);
    stepEdge();
    checkOutput("bp drain valid", 32'(bus.out_valid), 32'd0);
    clearBusy(5'd16);
    clearBusy(5'd18);
    clearBusy(5'd20);

    // rd=0 never marks busy; illegal words leave the scoreboard alone
    applyStimulus(1'b1, enc_i(12'h001, 1, 3'd0, 0), 4'd8, 1'b1);
    stepEdge();
    checkOutput("x0 addi rd", 32'(bus.out_rd), 32'd0);
    applyStimulus(1'b1, enc_r(7'h00, 0, 0, 3'd0, 6), 4'd9, 1'b1);
    checkOutput("x0 dep in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("x0 dep opcode", 32'(bus.out_opcode), 32'd23);
    applyStimulus(1'b1, enc_r(7'h20, 1, 2, 3'd1, 5), 4'd10, 1'b1);
    checkOutput("ill in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("ill pulse", 32'(illegal), 32'd1);
    checkOutput("ill no issue", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, enc_r(7'h00, 0, 5, 3'd0, 7), 4'd11, 1'b1);
    checkOutput("ill sb clean in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("ill pulse end", 32'(illegal), 32'd0);
    checkOutput("ill next rd", 32'(bus.out_rd), 32'd7);
    clearBusy(5'd6);
    clearBusy(5'd7);

    // Same-edge set and clear of x9: set must win
    applyStimulus(1'b1, enc_i(12'h005, 1, 3'd0, 9), 4'd12, 1'b1);
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    stepEdge();
    wb_valid = 1'b0;
    applyStimulus(1'b1, enc_r(7'h00, 0, 9, 3'd0, 10), 4'd13, 1'b1);
    checkOutput("setwins in_ready", 32'(bus.in_ready), 32'd0);
    clearBusy(5'd9);

    // Asynchronous reset with an op held and x5 busy
    applyStimulus(1'b1, 32'hFFD08293, 4'd14, 1'b0);
    stepEdge();
    checkOutput("rst pre valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    checkOutput("rst async valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst async opcode", 32'(bus.out_opcode), 32'd0);
    checkOutput("rst async rd", 32'(bus.out_rd), 32'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, enc_r(7'h00, 0, 5, 3'd0, 6), 4'd15, 1'b1);
    checkOutput("rst post in_ready", 32'(bus.in_ready), 32'd1);
    stepEdge();
    checkOutput("rst post opcode", 32'(bus.out_opcode), 32'd23);
    checkOutput("rst post valid", 32'(bus.out_valid), 32'd1);
    clearBusy(5'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Front end of the integer ALU. Accepts raw RV32I OP-IMM/OP instruction words over a valid/ready handshake.
- Translates each word into the ALU's internal opcode numbering (14..32), reads register operands and forms the immediate.
- Holds issue with a 32-entry register scoreboard until no hazard remains, then presents {opcode, rs1, rs2, imm, rd, tag} to the ALU stage through a one-entry output register.

Parameters:
- TAG_W, 4, width of the opaque per-instruction tag (warp/lane ID), carried through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction word valid
- in_ready  out  1  instruction word accepted when in_valid & in_ready
- in_instr  in  32  RV32I instruction word
- in_tag  in  TAG_W  tag travelling with the instruction
- rf_rs1_addr  out  5  combinational register-file read address, driven from in_instr[19:15]
- rf_rs2_addr  out  5  combinational register-file read address, driven from in_instr[24:20]
- rf_rs1_data  in  32  same-cycle read data
- rf_rs2_data  in  32  same-cycle read data
- out_valid  out  1  issued operation valid
- out_ready  in  1  ALU stage accepts
- out_opcode  out  8  internal ALU opcode, 14..32
- out_rs1, out_rs2, out_imm  out  32 each  operands
- out_rd  out  5  destination register
- out_tag  out  TAG_W  tag
- wb_valid  in  1  writeback completing
- wb_rd  in  5  register being written back
- illegal  out  1  one-cycle pulse: an unsupported word was consumed

Behaviour:
- Reset values: out_valid=0, out_opcode=0, out_rs1/out_rs2/out_imm=0, out_rd=0, out_tag=0, illegal=0, scoreboard=all 0. Reset mid-handshake drops any held operation.
- Opcode decode (opcode=in_instr[6:0], f3=[14:12], f7=[31:25]):
  - 0010011 with f3 = 000/010/011/100/110/111 -> ADDI 14, SLTI 15, SLTIU 16, XORI 17, ORI 18, ANDI 19.
  - 0010011 with f3=001, f7=0 -> SLLI 20.
  - 0010011 with f3=101: f7=0 -> SRLI 21; f7=0100000 -> SRAI 22.
  - 0110011 with {f7,f3}: ADD 23, SUB 24, SLL 25, SLT 26, SLTU 27, XOR 28, SRL 29, SRA 30, OR 31, AND 32.
  - Only f7=0 is legal for R-type, except 0100000 with f3=000 (SUB) or f3=101 (SRA).
  - Anything else is illegal.
- Immediate:
  - Non-shift I-type: sign-extended in_instr[31:20].
  - Shift-immediate: {27'0, in_instr[24:20]}.
  - R-type: out_imm=0.
- out_rs2 for I-type = rf_rs2_data (ALU ignores it). The rs2 hazard check applies to R-type only.
- Scoreboard busy[31:0] is registered; bit 0 is never set.
- hazard = busy[rs1] | (Rtype & busy[rs2]) | busy[rd]. WAW is included.
- can_load = ~out_valid | out_ready.
- in_ready:
  - Legal word: can_load & ~hazard.
  - Illegal word: 1, independent of hazard and out stage.
- Accept of a legal word:
  - Output register loads on the next edge; out_valid=1.
  - busy[rd] set if rd!=0.
  - Latency from accept to out_valid is 1 cycle.
- Accept of an illegal word: consumed, illegal=1 for 1 cycle, nothing issued, scoreboard unchanged.
- out_valid & out_ready without a new accept: out_valid clears next edge.
- Back-to-back accept and issue in the same cycle sustains 1 op/cycle.
- Holding: while out_valid & ~out_ready, every out_* holds stable.
- wb_valid clears busy[wb_rd] next edge. If the same edge sets and clears the same rd, set wins.
- No writeback bypass: a hazard stalls at least until the cycle after wb_valid (1-cycle penalty).
- rd=0 ops issue normally and never mark busy.

Decomposition:
- Shared package (common): localparam opcode constants ALU_OPC_ADDI=14 .. ALU_OPC_AND=32; RV opcode constants OPC_OP_IMM=7'b0010011, OPC_OP=7'b0110011; packed struct issue_pkt_t {opcode, rs1, rs2, imm, rd}.
- One sub-module: alu_issue_decode. Purely combinational: in_instr -> {opcode, imm, rs1/rs2/rd indices, is_rtype, legal}.
- Top keeps the handshake, output register and scoreboard.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), rf_rs1_data=0x10, scoreboard clear, out_ready=1 -> next cycle out_valid=1, opcode=14, imm=0xFFFFFFFD, rd=5, rs1=0x10; busy[5]=1.
- SUB x3,x1,x2 (0x402081B3) then SRAI x7,x6,4 (0x40435393) back-to-back -> opcodes 24 then 22, SRAI imm=4, in_ready high both cycles.
- ADD x6,x5,x0 right after ADDI x5 -> in_ready=0 until the cycle after wb_valid with wb_rd=5; then issues with opcode 23.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; releasing out_ready resumes at 1 op/cycle.
- in_instr=0x0000007F, and SLLI with f7=1 (0x02109093) -> each consumed with in_ready=1, illegal pulses 1 cycle, no out_valid, scoreboard unchanged.
- Assert rst while out_valid=1 and busy[5]=1 -> out_valid=0 and busy=0 immediately without a clock edge; the first post-reset ADD x6,x5,x0 issues without stall.
